transmitter: RTL and testbench
==============================

Name: transmitter

Overview:
- Serial-to-port demultiplexer with a seven-segment status display.
- Frame on SerIn, MSB first: start bit 0, 2-bit port id, 4-bit length N, then N data bits.
- Data bits are routed onto one of four outputs P0..P3 while SerOutValid is high; Done pulses at frame end.
- The 7-segment display shows the number of data bits remaining; sits between a serial source and four downstream consumers.

Parameters:
- None. Widths are fixed: port id 2 bits, length 4 bits, SSD 7 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clkEn  input  1  clock enable; state and counters advance only on edges where clkEn=1.
- SerIn  input  1  serial data in; idle level 1.
- SerOutValid  output  1  high while in the TRANSMIT state.
- Done  output  1  high for exactly the one enabled cycle spent in the DONE state.
- P0, P1, P2, P3  output  1 each  data outputs; the selected port equals SerIn during TRANSMIT, all others 0.
- SSD_Out  output  7  segments {g,f,e,d,c,b,a}, active-low hex digit of the remaining count.

Behaviour:
- Reset (async, any state): state IDLE, port_reg=0, cnt=0. Outputs: SerOutValid=0, Done=0, P0..P3=0, SSD_Out=7'b1000000 (digit 0).
- All transitions and shifts occur on the rising clk edge with clkEn=1. When clkEn=0, all registers hold and outputs keep the values decoded from the held state.
- IDLE: if SerIn=0 -> GET_PORT. Otherwise stay.
- GET_PORT, 2 enabled cycles: port_reg <= {port_reg[0], SerIn}. After the second bit -> GET_CNT.
- GET_CNT, 4 enabled cycles: cnt <= {cnt[2:0], SerIn}. After the fourth bit: if the assembled value is 0 -> DONE, else -> TRANSMIT.
- A 3-bit bit-index counter sequences GET_PORT and GET_CNT and is cleared on entry to each.
- TRANSMIT:
  - SerOutValid=1.
  - P[port_reg] = SerIn (combinational); the other P outputs are 0.
  - cnt decrements on each enabled edge; on the edge where cnt==1 -> DONE.
  - Exactly N data bits are passed.
- DONE: Done=1, SerOutValid=0, P all 0. Next enabled edge -> IDLE. SerIn is ignored in this cycle.
- SSD_Out: combinational hex decode of cnt (0-F) in every state, so it shows the count building up, then counting down.
  - Active-low encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Outside TRANSMIT, P0..P3 are all 0.
- The start bit is detected only in IDLE. Frames cannot overlap; back-to-back frames may start in the cycle after DONE.
- Reset asserted mid-frame aborts immediately to IDLE; the partial frame is discarded.

Optional Feature:
- Macro SSD_ACTIVE_HIGH_EN.
- Defined: SSD_Out is the bitwise inverse of the table above (active-high segments; reset value 7'b0111111).
- Undefined: active-low as specified above.

Decomposition:
- Shared package transmitter_pkg:
  - state enum IDLE/GET_PORT/GET_CNT/TRANSMIT/DONE.
  - widths PORT_W=2, CNT_W=4.
  - 16-entry hex-to-segment constant table.
- One natural sub-module: hex_to_ssd (4-bit in, 7-bit out, honours SSD_ACTIVE_HIGH_EN).

Test Plan:
- Reset: assert rst mid-idle -> all outputs 0, SSD_Out=1000000. Hold clkEn=1 and SerIn=1 for 10 cycles -> state stays IDLE, no outputs toggle.
- Full frame: SerIn 0,1,1,1,0,0,0 then 8 data bits 1,1,0,0,1,1,0,1 ->
  - SerOutValid=1 for exactly 8 cycles; P3 mirrors the data, P0..P2 stay 0.
  - SSD shows 8,7,…,1 (0000000 … 1111001).
  - Done=1 for one cycle, then IDLE with SSD=0.
- Zero length: SerIn 0,0,0,0,0,0,0 -> SerOutValid never asserts, Done=1 one cycle after the last count bit, P0..P3 remain 0.
- clkEn gating: drop clkEn for 5 cycles mid-TRANSMIT (port 1, N=3) -> state and SSD frozen, SerOutValid stays 1, P1 follows SerIn. After clkEn resumes, exactly 3 bits total are delivered.
- Reset mid-frame: assert rst during GET_CNT and during TRANSMIT -> immediate return to reset values. The next valid frame (port 2, N=1) delivers 1 bit on P2 and Done pulses.
- Back-to-back: second frame's start bit applied in the cycle after DONE -> recognized; port 0, N=2 delivers 2 bits on P0.

Source files
------------

// File: rtl/transmitter_pkg.sv
// Shared types and constants for the serial-to-port transmitter.
// Holds the FSM state encoding, field widths and the hex-to-segment table
// (active-low segments, bit order {g,f,e,d,c,b,a}).
package transmitter_pkg;

  localparam int PORT_W    = 2;
  localparam int CNT_W     = 4;
  localparam int SSD_W     = 7;
  localparam int IDX_W     = 3;
  localparam int NUM_PORTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    GET_PORT,
    GET_CNT,
    TRANSMIT,
    DONE
  } state_t;

  localparam logic [SSD_W-1:0] SSD_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/transmitter_if.sv
// Bundle of the serial input side and the demultiplexed output side.
// slave  : the transmitter itself (consumes SerIn/clkEn, drives outputs).
// master : the environment (serial source plus downstream consumers).
interface transmitter_if;
  import transmitter_pkg::*;

  logic             clkEn;
  logic             SerIn;
  logic             SerOutValid;
  logic             Done;
  logic             P0;
  logic             P1;
  logic             P2;
  logic             P3;
  logic [SSD_W-1:0] SSD_Out;

  modport slave (
    input  clkEn,
    input  SerIn,
    output SerOutValid,
    output Done,
    output P0,
    output P1,
    output P2,
    output P3,
    output SSD_Out
  );

  modport master (
    output clkEn,
    output SerIn,
    input  SerOutValid,
    input  Done,
    input  P0,
    input  P1,
    input  P2,
    input  P3,
    input  SSD_Out
  );

endinterface

// File: rtl/transmitter_hex_to_ssd.sv
// Hex digit to seven-segment decoder (hex_to_ssd).
// Build option: SSD_ACTIVE_HIGH_EN selects active-high segments (inverse of
// the package table); by default segments are active-low.
module transmitter_hex_to_ssd
  import transmitter_pkg::*;
(
  input  logic [CNT_W-1:0] hex,
  output logic [SSD_W-1:0] seg
);

`ifdef SSD_ACTIVE_HIGH_EN
  assign seg = ~SSD_TABLE[hex];
`else
  assign seg = SSD_TABLE[hex];
`endif

endmodule

// File: rtl/transmitter.sv
// Serial-to-port demultiplexer with remaining-count display.
// Frame (MSB first): start 0, 2-bit port id, 4-bit length N, N data bits.
// Data bits appear on the selected P output while SerOutValid is high; Done
// pulses for one enabled cycle at frame end. Everything advances only on
// edges with clkEn=1. SSD polarity is chosen by SSD_ACTIVE_HIGH_EN (see
// transmitter_hex_to_ssd).
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | line idle, waiting for a 0 start bit
// GET_PORT | shifting in the 2-bit port id
// GET_CNT  | shifting in the 4-bit length
// TRANSMIT | routing SerIn to the selected port, counting cnt down
// DONE     | one-cycle end-of-frame marker, SerIn ignored
module transmitter
  import transmitter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  transmitter_if.slave   bus
);

  state_t              state;
  logic [PORT_W-1:0]   port_reg;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic                valid_q;
  logic                done_q;
  logic [CNT_W-1:0]    cnt_next;
  logic [NUM_PORTS-1:0] p_vec;

  // Value the length register takes on a GET_CNT shift; also used to pick
  // the exit state so a zero-length frame skips TRANSMIT.
  assign cnt_next = {cnt[CNT_W-2:0], bus.SerIn};

  // Frame sequencer; SerOutValid/Done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      port_reg <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.clkEn) begin
      case (state)
        IDLE: begin
          if (!bus.SerIn) begin
            state   <= GET_PORT;
            bit_idx <= '0;
          end
        end
        GET_PORT: begin
          port_reg <= {port_reg[PORT_W-2:0], bus.SerIn};
          if (bit_idx == IDX_W'(PORT_W - 1)) begin
            state   <= GET_CNT;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        GET_CNT: begin
          cnt <= cnt_next;
          if (bit_idx == IDX_W'(CNT_W - 1)) begin
            bit_idx <= '0;
            if (cnt_next == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= TRANSMIT;
              valid_q <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        TRANSMIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pass-through of SerIn to the selected port; all ports 0 outside TRANSMIT.
  always_comb begin
    p_vec = '0;
    if (valid_q) p_vec[port_reg] = bus.SerIn;
  end

  assign bus.SerOutValid = valid_q;
  assign bus.Done        = done_q;
  assign bus.P0          = p_vec[0];
  assign bus.P1          = p_vec[1];
  assign bus.P2          = p_vec[2];
  assign bus.P3          = p_vec[3];

  transmitter_hex_to_ssd u_hex_to_ssd (
    .hex (cnt),
    .seg (bus.SSD_Out)
  );

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for transmitter: stimulus pushes expected port/SSD values
// per data bit and an expected bit count per frame; a monitor pops on every
// enabled cycle where SerOutValid or Done is seen.
module tb_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  transmitter_if bus ();

  transmitter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] p;
    logic [6:0] ssd;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   bits_seen = 0;

  function automatic logic [6:0] ssd_of(input int v);
    logic [6:0] s;
    case (v)
      0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;  3: s = 7'b0110000;
      4: s = 7'b0011001;  5: s = 7'b0010010;  6: s = 7'b0000010;  7: s = 7'b1111000;
      8: s = 7'b0000000;  9: s = 7'b0010000; 10: s = 7'b0001000; 11: s = 7'b0000011;
     12: s = 7'b1000110; 13: s = 7'b0100001; 14: s = 7'b0000110; default: s = 7'b0001110;
    endcase
`ifdef SSD_ACTIVE_HIGH_EN
    s = ~s;
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pvec();
    return {bus.P3, bus.P2, bus.P1, bus.P0};
  endfunction

  task automatic check_quiet(input string name);
    check({name, " ctl"}, {10'd0, bus.SerOutValid, bus.Done, pvec()}, 16'd0);
    check({name, " ssd"}, {9'd0, bus.SSD_Out}, {9'd0, ssd_of(0)});
  endtask

  task automatic send_bit(input logic b);
    bus.clkEn = 1'b1;
    bus.SerIn = b;
    @(posedge clk);
    #1;
  endtask

  // Full frame. gap >= 0 inserts 5 clkEn=0 cycles after data bit 'gap'.
  task automatic send_frame(input int port, input int n, input logic [15:0] data,
                            input int gap, input logic done_in);
    logic [3:0] nb;
    logic [1:0] pb;
    nb = 4'(n);
    pb = 2'(port);
    done_q.push_back(n);
    send_bit(1'b0);
    send_bit(pb[1]);
    send_bit(pb[0]);
    for (int j = 0; j < 4; j++) begin
      send_bit(nb[3-j]);
      check("ssd build", {9'd0, bus.SSD_Out}, {9'd0, ssd_of(n >> (3 - j))});
    end
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.p   = data[n-1-i] ? (4'b0001 << port) : 4'b0000;
      e.ssd = ssd_of(n - i);
      exp_q.push_back(e);
      send_bit(data[n-1-i]);
      if (i == gap) begin
        for (int k = 0; k < 5; k++) begin
          bus.clkEn = 1'b0;
          bus.SerIn = k[0];
          #1;
          check("gated p", {12'd0, pvec()}, {12'd0, k[0] ? (4'b0001 << port) : 4'b0000});
          check("gated valid", {15'd0, bus.SerOutValid}, 16'd1);
          check("gated ssd", {9'd0, bus.SSD_Out}, {9'd0, ssd_of(n - 1 - i)});
          @(posedge clk);
          #1;
        end
      end
    end
    send_bit(done_in);
    check_quiet("post-frame idle");
  endtask

  // Monitor: one sample per enabled cycle, mid-cycle.
  always begin
    @(negedge clk or posedge rst);
    if (rst) begin
      bits_seen = 0;
    end else if (bus.clkEn) begin
      if (bus.SerOutValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected valid", 16'd1, 16'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data p", {12'd0, pvec()}, {12'd0, e.p});
          check("data ssd", {9'd0, bus.SSD_Out}, {9'd0, e.ssd});
          bits_seen++;
        end
      end else if (pvec() != 4'd0) begin
        check("p idle", {12'd0, pvec()}, 16'd0);
      end
      if (bus.Done) begin
        if (done_q.size() == 0) begin
          check("unexpected done", 16'd1, 16'd0);
        end else begin
          int nexp;
          nexp = done_q.pop_front();
          check("bits per frame", 16'(bits_seen), 16'(nexp));
          check("valid at done", {15'd0, bus.SerOutValid}, 16'd0);
          bits_seen = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clkEn = 1'b0;
    bus.SerIn = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    // idle line stays idle
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      check_quiet("idle hold");
    end
    rst = 1'b1;
    #1;
    check_quiet("reset mid-idle");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full frame: port 3, N=8, data 11001101
    send_frame(3, 8, 16'h00CD, -1, 1'b1);

    // zero length
    send_frame(0, 0, 16'h0000, -1, 1'b1);

    // clkEn gating mid-TRANSMIT: port 1, N=3, data 101
    send_frame(1, 3, 16'h0005, 0, 1'b1);

    // reset during GET_CNT (port 3, partial length 11 -> SSD 3)
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("partial cnt ssd", {9'd0, bus.SSD_Out}, {9'd0, ssd_of(3)});
    bus.SerIn = 1'b1;
    rst = 1'b1;
    #1;
    check_quiet("reset in GET_CNT");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset during TRANSMIT: port 0, N=5, two bits delivered then abort
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.p   = 4'b0001;
      e.ssd = ssd_of(5 - i);
      exp_q.push_back(e);
      send_bit(1'b1);
    end
    bus.SerIn = 1'b1;
    rst = 1'b1;
    #1;
    check_quiet("reset in TRANSMIT");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // recovery frame: port 2, N=1
    send_frame(2, 1, 16'h0001, -1, 1'b1);

    // back-to-back: SerIn=0 in DONE is ignored, next start right after
    send_frame(0, 2, 16'h0002, -1, 1'b0);
    send_frame(0, 2, 16'h0001, -1, 1'b1);

    repeat (3) send_bit(1'b1);
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);
    check("done tokens drained", 16'(done_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
